mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

Shares the single memory port of the minimal SOPC between the CPU instruction-fetch port and the data (MEM-stage) port. It serialises requests onto one request/acknowledge memory interface, routes read data and acknowledges back to the owning requester, and raises a stall request to the pipeline controller while any requester is waiting. Data accesses win by default, and a starvation counter guarantees instruction fetches forward progress.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive data grants allowed while a fetch waits (1..15)
- TIMEOUT, 255, slave-ack watchdog limit in cycles (8-bit)

- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request, held until i_ack
- i_addr  in  ADDR_W  fetch address
- i_rdata  out  DATA_W  fetch read data, valid with i_ack
- i_ack  out  1  one-cycle fetch completion
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = write
- d_sel  in  DATA_W/8  byte enables
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_rdata  out  DATA_W  read data, valid with d_ack
- d_ack  out  1  one-cycle data completion
- m_cyc  out  1  memory transaction active
- m_we  out  1  memory write
- m_sel  out  DATA_W/8  memory byte enables (all ones for fetch)
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data
- m_ack  in  1  memory completion, one cycle
- stallreq_o  out  1  to pipeline controller
- err_o  out  1  one-cycle bus error pulse

## Operation
- States: IDLE, BUS_I, BUS_D.
- IDLE: nothing requested -> stay. d_req only -> BUS_D. i_req only -> BUS_I. Both -> BUS_D unless starve_cnt == STARVE_MAX, then BUS_I.
- On the grant edge, m_we/m_sel/m_addr/m_wdata are registered from the winner (fetch: we=0, sel=all ones, wdata=0) and m_cyc is set. They stay stable until completion.
- BUS_x with m_ack=1: combinationally drive x_ack=1 and x_rdata=m_rdata in the same cycle. Next edge: m_cyc=0, go to IDLE.
- A non-owner's ack is always 0; its rdata is held at 0.
- starve_cnt (4 bits) updates on each grant edge:
  - data grant while i_req=1 -> increment, saturating at STARVE_MAX
  - fetch grant, or i_req=0 -> clear to 0
- stallreq_o = (i_req & ~i_ack) | (d_req & ~d_ack). Purely combinational.
- Requesters present a new request in the cycle after their ack. The arbiter re-samples in IDLE.

## Timing
- Reset: state=IDLE; m_cyc, m_we, m_sel, m_addr, m_wdata, starve_cnt, watchdog all 0. Acks, rdata and err_o are 0.
- Reset asserted mid-transaction abandons it. No ack is issued and m_cyc drops immediately.
- Latency: req seen in IDLE at edge N -> m_cyc high after edge N. A zero-wait slave acks in cycle N+1, so ack reaches the requester in that same cycle.
- Throughput: one transaction per (slave latency + 1) cycles, because of one IDLE cycle between transactions.
- Simultaneous requests while the bus is busy wait in IDLE arbitration. Request lines are never sampled outside IDLE.
- m_ack in IDLE is ignored.

## Configuration
- ARB_TIMEOUT_EN defined:
  - An 8-bit watchdog counts cycles in BUS_x without m_ack.
  - When it reaches TIMEOUT, the arbiter asserts x_ack=1, x_rdata=0 and err_o=1 for one cycle, drops m_cyc, and returns to IDLE.
  - The watchdog clears on every grant.
- ARB_TIMEOUT_EN undefined:
  - No watchdog; the arbiter waits indefinitely.
  - err_o is tied to 0.

## Structure
- Shared package/defines: state encodings (ARB_IDLE, ARB_BUS_I, ARB_BUS_D), the active-low reset level constant, and the fetch all-ones select constant.
- Sub-module arb_watchdog holds the timeout counter and compare; it is instantiated only under ARB_TIMEOUT_EN. Everything else stays in one module.

## Test plan
- Reset release, i_req=1, i_addr=0x100, slave acks 1 cycle after m_cyc -> m_addr=0x100, m_sel=4'hF, i_ack for one cycle with i_rdata=m_rdata, stallreq_o low after ack.
- i_req and d_req asserted together, d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF -> data served first (m_we=1, m_wdata=0xDEADBEEF), then fetch; d_ack precedes i_ack.
- i_req held while d_req re-asserts after every ack, STARVE_MAX=4 -> exactly 4 data grants, then a fetch grant, then starve_cnt=0.
- Slave inserts 3 wait states -> m_cyc/m_addr stable for 4 cycles, stallreq_o high throughout, a single ack pulse.
- rst low during BUS_D wait -> m_cyc=0 immediately, no d_ack; after release, IDLE re-arbitrates the held d_req.
- ARB_TIMEOUT_EN, TIMEOUT=8, slave never acks -> d_ack=1, err_o=1, d_rdata=0 after 8 cycles, then IDLE. Without the macro, m_cyc stays high.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
// Shared definitions for the fetch/data memory-port arbiter: FSM state
// encodings, the reset level, the fetch byte-select fill bit and the
// saturating starvation-counter step.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BUS_I = 2'd1,
        ARB_BUS_D = 2'd2
    } arb_state_e;

    // rst is asserted low
    localparam logic RST_ACTIVE = 1'b0;

    // Fetches always read the whole word; replicated to the select width
    localparam logic FETCH_SEL_BIT = 1'b1;

    function automatic logic [3:0] starve_next(input logic [3:0] cnt,
                                               input logic [3:0] lim);
        if (cnt >= lim) begin
            return lim;
        end
        return cnt + 4'd1;
    endfunction

endpackage

// File: rtl/arb_watchdog.sv
// arb_watchdog
// Slave-acknowledge watchdog. Counts bus cycles without m_ack and flags
// the TIMEOUT-th such cycle so the arbiter can complete the access with
// an error. Built only when ARB_TIMEOUT_EN is defined.
//   clk, rst   : clock, async active-low reset
//   clear_i    : grant strobe, restarts the count
//   busy_i     : arbiter owns the bus
//   ack_i      : slave acknowledge
//   timeout_o  : combinational, high in the cycle the limit is hit
module arb_watchdog
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic busy_i,
    input  logic ack_i,
    output logic timeout_o
);

    // Cycle 1 of the wait sees count 0, so cycle TIMEOUT sees TIMEOUT-1
    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q;

    assign timeout_o = busy_i & ~ack_i & (cnt_q == LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (busy_i && !ack_i && !timeout_o) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one request/acknowledge memory port between the instruction-fetch
// port (i_*) and the data port (d_*). Data wins by default; a starvation
// counter forces a fetch grant after STARVE_MAX consecutive data grants
// while a fetch is waiting. Acks and read data are routed combinationally
// to the owner; stallreq_o is high while any requester is still waiting.
// Optional macro ARB_TIMEOUT_EN adds a slave-ack watchdog (arb_watchdog)
// that completes a stuck access with x_ack, zero rdata and an err_o pulse;
// without it err_o is tied low and the arbiter waits indefinitely.
//   clk, rst            : clock, async active-low reset
//   i_req/i_addr        : fetch request in; i_rdata/i_ack out
//   d_req/d_we/d_sel/d_addr/d_wdata : data request in; d_rdata/d_ack out
//   m_cyc/m_we/m_sel/m_addr/m_wdata : memory request out (registered)
//   m_rdata/m_ack       : memory response in
//   stallreq_o, err_o   : pipeline stall request, bus error pulse
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_ack,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_sel,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ack,
    output logic                m_cyc,
    output logic                m_we,
    output logic [DATA_W/8-1:0] m_sel,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_ack,
    output logic                stallreq_o,
    output logic                err_o
);

    localparam int SEL_W = DATA_W / 8;
    localparam logic [SEL_W-1:0] FETCH_SEL = {SEL_W{FETCH_SEL_BIT}};
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    generate
        if (STARVE_MAX < 1 || STARVE_MAX > 15 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
            $error("mem_bus_arbiter: STARVE_MAX must be 1..15 and TIMEOUT 1..255");
        end
    endgenerate

    arb_state_e state_q;
    logic [3:0] starve_q;
    logic       busy;
    logic       timeout;
    logic       done;
    logic       grant_i;
    logic       grant_d;

    assign busy = (state_q != ARB_IDLE);

`ifdef ARB_TIMEOUT_EN
    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (grant_i | grant_d),
        .busy_i    (busy),
        .ack_i     (m_ack),
        .timeout_o (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    assign done = busy & (m_ack | timeout);

    // Request lines only matter in IDLE; data wins unless the fetch has
    // been passed over STARVE_MAX times in a row.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state_q == ARB_IDLE) begin
            if (d_req && !(i_req && starve_q == STARVE_LIM)) begin
                grant_d = 1'b1;
            end else if (i_req) begin
                grant_i = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            state_q  <= ARB_IDLE;
            starve_q <= '0;
            m_cyc    <= 1'b0;
            m_we     <= 1'b0;
            m_sel    <= '0;
            m_addr   <= '0;
            m_wdata  <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (grant_d) begin
                        state_q  <= ARB_BUS_D;
                        m_cyc    <= 1'b1;
                        m_we     <= d_we;
                        m_sel    <= d_sel;
                        m_addr   <= d_addr;
                        m_wdata  <= d_wdata;
                        starve_q <= i_req ? starve_next(starve_q, STARVE_LIM) : 4'd0;
                    end else if (grant_i) begin
                        state_q  <= ARB_BUS_I;
                        m_cyc    <= 1'b1;
                        m_we     <= 1'b0;
                        m_sel    <= FETCH_SEL;
                        m_addr   <= i_addr;
                        m_wdata  <= '0;
                        starve_q <= 4'd0;
                    end
                end
                ARB_BUS_I, ARB_BUS_D: begin
                    if (done) begin
                        state_q <= ARB_IDLE;
                        m_cyc   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    m_cyc   <= 1'b0;
                end
            endcase
        end
    end

    // A watchdog completion returns zero data; timeout never coincides with m_ack
    assign i_ack   = (state_q == ARB_BUS_I) & done;
    assign d_ack   = (state_q == ARB_BUS_D) & done;
    assign i_rdata = (state_q == ARB_BUS_I && m_ack) ? m_rdata : '0;
    assign d_rdata = (state_q == ARB_BUS_D && m_ack) ? m_rdata : '0;
    assign err_o   = timeout;

    assign stallreq_o = (i_req & ~i_ack) | (d_req & ~d_ack);

endmodule
